// File: rtl/sum_sevenseg_display.sv
// Converts a captured 5-bit adder result to two BCD digits (sequential double dabble)
// and scans them onto a 4-digit common-anode display. Define CARRY_DP_EN to light dp on carry.
module sum_sevenseg_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int IN_W        = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] sum_in,
  input  logic            load,
  output logic            busy,
  output logic [6:0]      seg,
  output logic [3:0]      an,
  output logic            dp
);

  localparam int CNT_W     = $clog2(REFRESH_DIV);
  localparam int BIT_CNT_W = $clog2(IN_W + 1);
  localparam int DD_W      = 8 + IN_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_capture;
  logic                 w_shift_en;
  logic                 w_update;
  logic                 r_busy;

  logic [IN_W-1:0]      r_shreg;
  logic [7:0]           r_bcd;
  logic [BIT_CNT_W-1:0] r_bit_cnt;
  logic [7:0]           w_bcd_adj;
  logic [DD_W-1:0]      w_dd_next;

  logic [3:0]           r_tens;
  logic [3:0]           r_units;
  logic [CNT_W-1:0]     r_refresh_cnt;
  logic                 r_digit_idx;

  logic [6:0]           w_seg_next;
  logic [3:0]           w_an_next;
  logic                 w_dp_next;
  logic [6:0]           r_seg;
  logic [3:0]           r_an;
  logic                 r_dp;

  function automatic logic [7:0] bcd_adjust(input logic [7:0] b);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = (b[7:4] >= 4'd5) ? (b[7:4] + 4'd3) : b[7:4];
    lo = (b[3:0] >= 4'd5) ? (b[3:0] + 4'd3) : b[3:0];
    return {hi, lo};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0010000;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_next_state = ST_SHIFT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_bit_cnt == BIT_CNT_W'(IN_W - 1)) begin
          w_next_state = ST_UPDATE;
        end else begin
          w_next_state = ST_SHIFT;
        end
      end
      ST_UPDATE: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    w_capture  = 1'b0;
    w_shift_en = 1'b0;
    w_update   = 1'b0;
    case (r_state)
      ST_IDLE:   w_capture  = load;
      ST_SHIFT:  w_shift_en = 1'b1;
      ST_UPDATE: w_update   = 1'b1;
      default: begin
        w_capture  = 1'b0;
        w_shift_en = 1'b0;
        w_update   = 1'b0;
      end
    endcase
  end

  // busy registered from the next state so it tracks SHIFT/UPDATE exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
    end
  end

  assign w_bcd_adj = bcd_adjust(r_bcd);
  assign w_dd_next = {w_bcd_adj, r_shreg} << 1;

  // Double-dabble datapath: adjust nibbles, then shift one input bit into the BCD register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg   <= '0;
      r_bcd     <= 8'd0;
      r_bit_cnt <= '0;
    end else if (w_capture) begin
      r_shreg   <= sum_in;
      r_bcd     <= 8'd0;
      r_bit_cnt <= '0;
    end else if (w_shift_en) begin
      {r_bcd, r_shreg} <= w_dd_next;
      r_bit_cnt        <= r_bit_cnt + BIT_CNT_W'(1);
    end else begin
      r_shreg   <= r_shreg;
      r_bcd     <= r_bcd;
      r_bit_cnt <= r_bit_cnt;
    end
  end

  // Display digit registers, refreshed only once a conversion completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tens  <= 4'd0;
      r_units <= 4'd0;
    end else if (w_update) begin
      r_tens  <= r_bcd[7:4];
      r_units <= r_bcd[3:0];
    end else begin
      r_tens  <= r_tens;
      r_units <= r_units;
    end
  end

`ifdef CARRY_DP_EN
  logic r_carry;

  // Carry is latched at capture time, alongside the shift register load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (w_capture) begin
      r_carry <= sum_in[IN_W-1];
    end else begin
      r_carry <= r_carry;
    end
  end

  assign w_dp_next = ~(~r_digit_idx & r_carry);
`else
  assign w_dp_next = 1'b1;
`endif

  // Refresh counter and digit slot index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= 1'b0;
    end else if (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
      r_refresh_cnt <= '0;
      r_digit_idx   <= ~r_digit_idx;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
      r_digit_idx   <= r_digit_idx;
    end
  end

  // Digit slot decode with leading-zero blanking of the tens position
  always_comb begin
    w_seg_next = 7'h7F;
    w_an_next  = 4'hF;
    if (r_digit_idx == 1'b0) begin
      w_an_next  = 4'b1110;
      w_seg_next = seg_code(r_units);
    end else if (r_tens == 4'd0) begin
      w_an_next  = 4'b1111;
      w_seg_next = 7'h7F;
    end else begin
      w_an_next  = 4'b1101;
      w_seg_next = seg_code(r_tens);
    end
  end

  // Registered pin drivers keep seg/an glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 7'h7F;
      r_an  <= 4'hF;
      r_dp  <= 1'b1;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
      r_dp  <= w_dp_next;
    end
  end

  assign busy = r_busy;
  assign seg  = r_seg;
  assign an   = r_an;
  assign dp   = r_dp;

endmodule

// File: tb/tb_sum_sevenseg_display.sv
// Randomized self-checking bench for sum_sevenseg_display against a cycle-level
// behavioural model built from decimal arithmetic (value / 10, value % 10).
module tb_sum_sevenseg_display;

  localparam int REFRESH_DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] sum_in;
  logic       load;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [6:0] seg_table [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

  // Model state
  int         m_ticks;
  int         m_tens;
  int         m_units;
  int         m_busy_left;
  int         m_pending;
  logic       m_carry;
  logic [6:0] m_seg;
  logic [3:0] m_an;
  logic       m_dp;

  sum_sevenseg_display #(
    .REFRESH_DIV(REFRESH_DIV),
    .IN_W       (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sum_in(sum_in),
    .load  (load),
    .busy  (busy),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ticks     = 0;
    m_tens      = 0;
    m_units     = 0;
    m_busy_left = 0;
    m_pending   = 0;
    m_carry     = 1'b0;
    m_seg       = 7'h7F;
    m_an        = 4'hF;
    m_dp        = 1'b1;
  endtask

  // One rising edge of the model; pin outputs reflect the state before the edge
  task automatic model_edge(input logic ld, input logic [4:0] v);
    int idx;
    idx = (m_ticks / REFRESH_DIV) % 2;
    if (idx == 0) begin
      m_an  = 4'b1110;
      m_seg = seg_table[m_units];
    end else if (m_tens == 0) begin
      m_an  = 4'b1111;
      m_seg = 7'h7F;
    end else begin
      m_an  = 4'b1101;
      m_seg = seg_table[m_tens];
    end
`ifdef CARRY_DP_EN
    m_dp = (idx == 0 && m_carry) ? 1'b0 : 1'b1;
`else
    m_dp = 1'b1;
`endif
    m_ticks++;
    if (m_busy_left == 0) begin
      if (ld) begin
        m_busy_left = 6;
        m_pending   = int'(v);
        m_carry     = v[4];
      end
    end else begin
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_tens  = m_pending / 10;
        m_units = m_pending % 10;
      end
    end
  endtask

  task automatic check_outputs();
    check_value("busy", 32'(busy), 32'(m_busy_left != 0));
    check_value("seg",  32'(seg),  32'(m_seg));
    check_value("an",   32'(an),   32'(m_an));
    check_value("dp",   32'(dp),   32'(m_dp));
  endtask

  // Called at a falling edge: check, drive, advance one clock, return at next falling edge
  task automatic cycle(input logic ld, input logic [4:0] v);
    check_outputs();
    load   = ld;
    sum_in = v;
    @(posedge clk);
    model_edge(ld, v);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 5'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    sum_in = 5'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    idle(10);
    cycle(1'b1, 5'd23);
    idle(20);
    cycle(1'b1, 5'd7);
    idle(20);
    cycle(1'b1, 5'd31);
    idle(20);

    // load during busy is dropped; a later load is taken
    cycle(1'b1, 5'd23);
    cycle(1'b0, 5'd0);
    cycle(1'b1, 5'd5);
    idle(12);
    cycle(1'b1, 5'd5);
    idle(20);

    // asynchronous reset in the middle of SHIFT
    cycle(1'b1, 5'd23);
    cycle(1'b0, 5'd0);
    cycle(1'b0, 5'd0);
    #2 rst_n = 1'b0;
    #1;
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_seg",  32'(seg),  32'h7F);
    check_value("rst_an",   32'(an),   32'hF);
    check_value("rst_dp",   32'(dp),   32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);

    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 5) == 0), 5'($urandom_range(0, 31)));
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/sum_sevenseg_display.md
Name: sum_sevenseg_display

Overview:
- Downstream consumer of the 4-bit ripple-carry adder's 5-bit result {Cout,S3..S0}, range 0..31.
- Captures the result on a load strobe and converts it to two BCD digits with a sequential double-dabble FSM.
- Time-multiplexes the digits onto the Basys3 4-digit common-anode seven-segment display.
- Sits between the adder outputs and the board display pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2.
- IN_W, 5, input width; fixed at 5 for this block. Other values are unsupported.

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- sum_in  input  5  adder result; bit 4 = carry out
- load  input  1  single-cycle capture strobe
- busy  output  1  high while a conversion is in progress
- seg  output  7  segments, active-low; seg[6:0] = {g,f,e,d,c,b,a}
- an  output  4  digit anodes, active-low; an[0] = rightmost digit
- dp  output  1  decimal point, active-low

Behaviour:
- Reset values (asynchronous, rst_n low):
  - seg = 7'h7F, an = 4'hF, dp = 1, busy = 0.
  - Stored digits tens = 0, units = 0, stored carry = 0.
  - FSM = IDLE, refresh counter = 0, digit index = 0.
- FSM states are IDLE, SHIFT and UPDATE.
- IDLE:
  - When load = 1, capture sum_in into a 5-bit shift register.
  - Clear the 8-bit BCD register and bit counter, latch sum_in[4] as stored carry, go to SHIFT.
  - load = 0 holds IDLE.
- SHIFT, one bit per cycle for 5 cycles:
  - First add 3 to each BCD nibble that is >= 5.
  - Then shift {bcd, shreg} left by 1 and increment the counter.
  - After the 5th shift, go to UPDATE.
- UPDATE: copy the BCD register into the display registers (tens = bcd[7:4], units = bcd[3:0]), then go to IDLE.
- busy:
  - busy = 1 in SHIFT and UPDATE, 0 in IDLE.
  - Strobe at cycle N gives busy high for cycles N+1..N+6; display registers hold the new value from cycle N+7.
- load while busy is ignored and does not queue. sum_in changes are ignored outside the capture cycle.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, the digit index toggles 0 <-> 1.
- seg/an/dp are registered, updated on the cycle after index or display data changes.
- Index 0: an = 4'b1110, seg = code(units).
- Index 1: an = 4'b1101, seg = code(tens).
  - If tens = 0, tens is blanked with an = 4'b1111 and seg = 7'h7F (leading-zero blanking).
- an[3:2] are always high.
- Codes, active-low {g..a}:

  | Digit | Code |
  |---|---|
  | 0 | 1000000 |
  | 1 | 1111001 |
  | 2 | 0100100 |
  | 3 | 0110000 |
  | 4 | 0011001 |
  | 5 | 0010010 |
  | 6 | 0000010 |
  | 7 | 1111000 |
  | 8 | 0000000 |
  | 9 | 0010000 |

  Any other value maps to 7'h7F.
- Display continues scanning the old value during conversion, with no glitch on seg/an.
- Reset mid-conversion aborts to IDLE with the display cleared to "0" and busy = 0.

Optional Feature:
- Macro: CARRY_DP_EN.
- Defined: dp = 0 while index = 0 and stored carry = 1; otherwise dp = 1. This marks adder overflow beyond 4 bits.
- Undefined: dp is constant 1, and stored carry logic is omitted.

Test Plan:
All scenarios use REFRESH_DIV = 4.
- Reset release, no load -> an = 1110 and seg = 1000000 on the units slot; tens slot an = 1111; busy = 0.
- sum_in = 5'd23, load pulse at cycle N -> busy high N+1..N+6; then units seg = 0110000 ("3") with an = 1110, and tens seg = 0100100 ("2") with an = 1101.
- sum_in = 5'd7 -> units "7" (1111000), tens blanked (an = 1111 on index 1).
- sum_in = 5'd31 with CARRY_DP_EN -> "31", dp = 0 only during the units slot. Without the macro, dp stays 1.
- Second load during busy with sum_in = 5'd5 -> ignored; display shows the first value. A load after busy falls displays "5".
- rst_n low during SHIFT -> busy = 0, seg = 7'h7F and an = 4'hF immediately (asynchronously); after release the display shows "0".
